// File: rtl/call_stack_if.sv
// Decoder-to-stack link: push request/data, pop request, combinational top-of-stack return.
// Latency: none of its own; pure wiring between decoder and stack.
// Backpressure: none; the stack accepts every request and reports drops through status flags.
interface call_stack_if #(
  parameter int WIDTH = 8
);
  logic             stack_push_enable;
  logic [WIDTH-1:0] stack_push_data;
  logic             stack_pop_enable;
  logic [WIDTH-1:0] stack_pop_data;

  // Decoder side: issues push/pop, consumes the top-of-stack value
  modport master (
    output stack_push_enable,
    output stack_push_data,
    output stack_pop_enable,
    input  stack_pop_data
  );

  // Stack side: services push/pop, presents the top-of-stack value
  modport slave (
    input  stack_push_enable,
    input  stack_push_data,
    input  stack_pop_enable,
    output stack_pop_data
  );
endinterface

// File: rtl/call_stack.sv
// LIFO for decoder PSH/POP data and CAL/RTN return addresses, with occupancy and sticky error status.
// Latency: top-of-stack is combinational (zero-cycle read); push/pop/replace commit on the next rising edge.
// Backpressure: none; pushes while full are dropped (overflow), pops while empty are ignored (underflow).
module call_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  call_stack_if.slave      stk,
  input  logic             err_clear,
  output logic             stack_full,
  output logic             stack_empty,
  output logic [CNT_W-1:0] stack_count,
  output logic             stack_overflow,
  output logic             stack_underflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] sp;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  logic do_replace;
  logic do_push;
  logic do_pop;
  logic ev_overflow;
  logic ev_underflow;

  // sp counts valid entries, so sp-1 addresses the top and sp the next free slot
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == CNT_W'(DEPTH));
  assign stack_count = sp;
  assign top_idx     = AW'(sp - CNT_W'(1));
  assign wr_idx      = sp[AW-1:0];

  // Empty stack reads as zero rather than exposing a stale entry
  assign stk.stack_pop_data = stack_empty ? '0 : mem[top_idx];

  // Classify this cycle's request into exactly one storage action plus error events
  always_comb begin
    do_replace   = 1'b0;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    ev_overflow  = 1'b0;
    ev_underflow = 1'b0;
    // Push+pop on a non-empty stack overwrites the top in place, even when full
    do_replace   = stk.stack_push_enable && stk.stack_pop_enable && !stack_empty;
    // A push alongside a pop on an empty stack still proceeds
    do_push      = stk.stack_push_enable && !do_replace && !stack_full;
    do_pop       = stk.stack_pop_enable && !stk.stack_push_enable && !stack_empty;
    ev_overflow  = stk.stack_push_enable && !stk.stack_pop_enable && stack_full;
    ev_underflow = stk.stack_pop_enable && stack_empty;
  end

  // Entry storage; never cleared, and writes are suppressed while in reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_replace) begin
        mem[top_idx] <= stk.stack_push_data;
      end else if (do_push) begin
        mem[wr_idx] <= stk.stack_push_data;
      end
    end
  end

  // Stack pointer saturates at 0 and DEPTH because push/pop are pre-qualified
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + CNT_W'(1);
    end else if (do_pop) begin
      sp <= sp - CNT_W'(1);
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      if (ev_overflow) begin
        stack_overflow <= 1'b1;
      end else if (err_clear) begin
        stack_overflow <= 1'b0;
      end
      if (ev_underflow) begin
        stack_underflow <= 1'b1;
      end else if (err_clear) begin
        stack_underflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus randomized traffic against a queue model.
// Latency: inputs applied after each rising edge; same-cycle pop data checked before the next edge.
// Backpressure: none; overflow/underflow drops are modelled and checked.
module tb_call_stack;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             err_clear;
  logic             stack_full;
  logic             stack_empty;
  logic [CNT_W-1:0] stack_count;
  logic             stack_overflow;
  logic             stack_underflow;

  int tests_run = 0;
  int fails     = 0;

  call_stack_if #(.WIDTH(WIDTH)) stk_if ();

  call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .stk             (stk_if.slave),
    .err_clear       (err_clear),
    .stack_full      (stack_full),
    .stack_empty     (stack_empty),
    .stack_count     (stack_count),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack, plus sticky flags
  logic [WIDTH-1:0] q[$];
  bit               m_of;
  bit               m_uf;

  function automatic logic [WIDTH-1:0] m_top();
    if (q.size() == 0) return '0;
    return q[q.size()-1];
  endfunction

  task automatic model_step(input bit psh, input bit pp, input logic [WIDTH-1:0] d,
                            input bit clr, input bit r);
    bit ev_of;
    bit ev_uf;
    ev_of = 1'b0;
    ev_uf = 1'b0;
    if (r) begin
      q.delete();
      m_of = 1'b0;
      m_uf = 1'b0;
    end else begin
      if (pp && q.size() == 0) ev_uf = 1'b1;
      if (psh && pp && q.size() > 0) begin
        q[q.size()-1] = d;
      end else begin
        if (psh) begin
          if (q.size() < DEPTH) q.push_back(d);
          else ev_of = 1'b1;
        end else if (pp && q.size() > 0) begin
          void'(q.pop_back());
        end
      end
      m_of = ev_of ? 1'b1 : (clr ? 1'b0 : m_of);
      m_uf = ev_uf ? 1'b1 : (clr ? 1'b0 : m_uf);
    end
  endtask

  // Apply inputs for the coming edge and let combinational outputs settle
  task automatic drive(input bit psh, input bit pp, input logic [WIDTH-1:0] d,
                       input bit clr, input bit r);
    stk_if.stack_push_enable = psh;
    stk_if.stack_pop_enable  = pp;
    stk_if.stack_push_data   = d;
    err_clear                = clr;
    rst                      = r;
    #1;
  endtask

  // Commit the driven inputs on the next edge and advance the model to match
  task automatic tick();
    bit               psh;
    bit               pp;
    bit               clr;
    bit               r;
    logic [WIDTH-1:0] d;
    psh = stk_if.stack_push_enable;
    pp  = stk_if.stack_pop_enable;
    clr = err_clear;
    r   = rst;
    d   = stk_if.stack_push_data;
    @(posedge clk);
    #1;
    model_step(psh, pp, d, clr, r);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic cyc(input bit psh, input bit pp, input logic [WIDTH-1:0] d,
                     input bit clr, input bit r);
    drive(psh, pp, d, clr, r);
    tick();
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (stack_count !== '0) begin
      fails++; $display("FAIL reset_count: got %0d want 0", stack_count);
    end
    tests_run++;
    if ({stack_empty, stack_full} !== 2'b10) begin
      fails++; $display("FAIL reset_empty_full: got %b want 10", {stack_empty, stack_full});
    end
    tests_run++;
    if (stk_if.stack_pop_data !== 8'h00) begin
      fails++; $display("FAIL reset_pop_data: got %h want 00", stk_if.stack_pop_data);
    end
    tests_run++;
    if ({stack_overflow, stack_underflow} !== 2'b00) begin
      fails++; $display("FAIL reset_flags: got %b want 00", {stack_overflow, stack_underflow});
    end
  endtask

  task automatic test_lifo();
    logic [WIDTH-1:0] exp_vals [3];
    exp_vals[0] = 8'h33; exp_vals[1] = 8'h22; exp_vals[2] = 8'h11;
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    tests_run++;
    if (stack_count !== CNT_W'(3) || stk_if.stack_pop_data !== 8'h33) begin
      fails++; $display("FAIL lifo_after_push: got count %0d top %h want 3 33", stack_count, stk_if.stack_pop_data);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
      tests_run++;
      if (stk_if.stack_pop_data !== exp_vals[i]) begin
        fails++; $display("FAIL lifo_pop%0d: got %h want %h", i, stk_if.stack_pop_data, exp_vals[i]);
      end
      tick();
    end
    tests_run++;
    if (stack_empty !== 1'b1 || stk_if.stack_pop_data !== 8'h00) begin
      fails++; $display("FAIL lifo_drained: got empty %b top %h want 1 00", stack_empty, stk_if.stack_pop_data);
    end
  endtask

  task automatic test_overflow();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
    tests_run++;
    if (stack_full !== 1'b1 || stack_count !== CNT_W'(DEPTH)) begin
      fails++; $display("FAIL ovf_full: got full %b count %0d want 1 %0d", stack_full, stack_count, DEPTH);
    end
    tests_run++;
    if (stack_overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_not_yet: got %b want 0", stack_overflow);
    end
    cyc(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    tests_run++;
    if (stack_overflow !== 1'b1 || stack_count !== CNT_W'(DEPTH) || stk_if.stack_pop_data !== 8'h0F) begin
      fails++; $display("FAIL ovf_drop: got ovf %b count %0d top %h want 1 16 0f",
                        stack_overflow, stack_count, stk_if.stack_pop_data);
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
    tests_run++;
    if (stack_underflow !== 1'b1 || stack_count !== '0 || stk_if.stack_pop_data !== 8'h00) begin
      fails++; $display("FAIL udf_set: got udf %b count %0d top %h want 1 0 00",
                        stack_underflow, stack_count, stk_if.stack_pop_data);
    end
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (stack_underflow !== 1'b0) begin
      fails++; $display("FAIL udf_clear: got %b want 0", stack_underflow);
    end
    cyc(1'b0, 1'b1, '0, 1'b1, 1'b0);
    tests_run++;
    if (stack_underflow !== 1'b1) begin
      fails++; $display("FAIL udf_set_wins: got %b want 1", stack_underflow);
    end
  endtask

  task automatic test_replace();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h09, 1'b0, 1'b0);
    tests_run++;
    if (stk_if.stack_pop_data !== 8'h05) begin
      fails++; $display("FAIL repl_old_top: got %h want 05", stk_if.stack_pop_data);
    end
    tick();
    tests_run++;
    if (stk_if.stack_pop_data !== 8'h09 || stack_count !== CNT_W'(1)) begin
      fails++; $display("FAIL repl_new_top: got top %h count %0d want 09 1", stk_if.stack_pop_data, stack_count);
    end
    for (int i = 1; i < DEPTH; i++) cyc(1'b1, 1'b0, WIDTH'(8'h50 + i), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    tests_run++;
    if (stk_if.stack_pop_data !== 8'h5F) begin
      fails++; $display("FAIL repl_full_old_top: got %h want 5f", stk_if.stack_pop_data);
    end
    tick();
    tests_run++;
    if (stack_count !== CNT_W'(DEPTH) || stack_overflow !== 1'b0 || stk_if.stack_pop_data !== 8'h77) begin
      fails++; $display("FAIL repl_full: got count %0d ovf %b top %h want 16 0 77",
                        stack_count, stack_overflow, stk_if.stack_pop_data);
    end
  endtask

  task automatic test_call_return();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h07, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h08, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    tests_run++;
    if (stk_if.stack_pop_data !== 8'h42) begin
      fails++; $display("FAIL rtn_addr: got %h want 42", stk_if.stack_pop_data);
    end
    tick();
    tests_run++;
    if (stack_count !== '0 || stack_empty !== 1'b1) begin
      fails++; $display("FAIL rtn_drained: got count %0d empty %b want 0 1", stack_count, stack_empty);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
    tests_run++;
    if (stack_count !== '0 || stack_empty !== 1'b1 || stk_if.stack_pop_data !== 8'h00) begin
      fails++; $display("FAIL rstmid_state: got count %0d empty %b top %h want 0 1 00",
                        stack_count, stack_empty, stk_if.stack_pop_data);
    end
    tests_run++;
    if ({stack_overflow, stack_underflow} !== 2'b00) begin
      fails++; $display("FAIL rstmid_flags: got %b want 00", {stack_overflow, stack_underflow});
    end
    cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
    tests_run++;
    if (stack_underflow !== 1'b1 || stack_count !== '0) begin
      fails++; $display("FAIL rstmid_pop_udf: got udf %b count %0d want 1 0", stack_underflow, stack_count);
    end
  endtask

  task automatic test_random();
    bit               psh;
    bit               pp;
    bit               clr;
    bit               r;
    logic [WIDTH-1:0] d;
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      // Phases bias toward filling or draining so both saturation limits are exercised
      psh = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
      pp  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
      clr = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 79) == 0);
      d   = WIDTH'($urandom);
      drive(psh, pp, d, clr, r);
      tests_run++;
      if (stk_if.stack_pop_data !== m_top()) begin
        fails++; $display("FAIL rand_top[%0d]: got %h want %h", i, stk_if.stack_pop_data, m_top());
      end
      tick();
      tests_run++;
      if (int'(stack_count) !== q.size() ||
          stack_full  !== (q.size() == DEPTH) ||
          stack_empty !== (q.size() == 0) ||
          stack_overflow  !== m_of ||
          stack_underflow !== m_uf) begin
        fails++;
        $display("FAIL rand_state[%0d]: got cnt %0d f %b e %b ovf %b udf %b want cnt %0d ovf %b udf %b",
                 i, stack_count, stack_full, stack_empty, stack_overflow, stack_underflow,
                 q.size(), m_of, m_uf);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    stk_if.stack_push_enable = 1'b0;
    stk_if.stack_pop_enable  = 1'b0;
    stk_if.stack_push_data   = '0;
    err_clear                = 1'b0;
    rst                      = 1'b1;
    m_of                     = 1'b0;
    m_uf                     = 1'b0;
    #1;
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace();
    test_call_return();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
